// File: rtl/spi_master_datapath.sv
// Datapath for the SPI master FSM: host handshake, sclk divider with half-period strobes,
// serializer and inter-frame gap timer. Define SPI_LSB_FIRST_EN to shift LSB first.
module spi_master_datapath #(
  parameter int DATA_W      = 8,
  parameter int HALF_PERIOD = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              inc_bit,
  input  logic              idle,
  input  logic              count,
  output logic              bit_in,
  output logic              sclk_in,
  output logic              start,
  output logic              low_t,
  output logic              high_t,
  output logic              last_bit,
  output logic              done
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int DIV_W = $clog2(HALF_PERIOD + 1);
  localparam int GAP_W = $clog2(WAIT_CYCLES + 1);

  localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(WAIT_CYCLES - 1);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              sclk_q, sclk_d;
  logic              start_q, start_d;
  logic              accept;
  logic              tc;

  assign tx_ready = idle && !start_q;
  assign accept   = tx_valid && tx_ready;
  assign tc       = !idle && (div_cnt_q == DIV_LAST);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    start_d   = start_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (accept) begin
      start_d   = 1'b1;
      shreg_d   = tx_data;
      bit_cnt_d = '0;
    end else begin
      // The request is held until the FSM is seen to have left IDLE.
      if (!idle) start_d = 1'b0;
      if (inc_bit) begin
`ifdef SPI_LSB_FIRST_EN
        shreg_d = shreg_q >> 1;
`else
        shreg_d = shreg_q << 1;
`endif
        if (bit_cnt_q != BIT_FULL) bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    div_cnt_d = '0;
    sclk_d    = 1'b0;
    if (!idle) begin
      if (tc) begin
        div_cnt_d = '0;
        sclk_d    = !sclk_q;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
        sclk_d    = sclk_q;
      end
    end
  end

  always_comb begin
    gap_cnt_d = '0;
    // Saturate on the terminal value so done stays high while count is held.
    if (count) gap_cnt_d = (gap_cnt_q == GAP_LAST) ? gap_cnt_q : gap_cnt_q + 1'b1;
  end

  // NOTE: state registers update with non-blocking assignments only, so every flop samples
  // pre-edge values regardless of process order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the shift register is reset too, so bit_in reads a defined 0 before the first word.
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      gap_cnt_q <= '0;
      sclk_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sclk_q    <= sclk_d;
      start_q   <= start_d;
    end
  end

`ifdef SPI_LSB_FIRST_EN
  assign bit_in = shreg_q[0];
`else
  assign bit_in = shreg_q[DATA_W-1];
`endif

  assign sclk_in  = sclk_q;
  assign start    = start_q;
  assign low_t    = tc && !sclk_q;
  assign high_t   = tc && sclk_q;
  assign last_bit = (bit_cnt_q == BIT_LAST);
  assign done     = count && (gap_cnt_q == GAP_LAST);

endmodule

// File: tb/tb_spi_master_datapath.sv
// Self-checking bench for spi_master_datapath: a frame-level model checked every cycle,
// plus directed frames with hand-computed expectations.
module tb_spi_master_datapath;

  localparam int DATA_W      = 8;
  localparam int HALF_PERIOD = 4;
  localparam int WAIT_CYCLES = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              inc_bit = 1'b0;
  logic              idle = 1'b1;
  logic              count = 1'b0;
  logic              tx_ready, bit_in, sclk_in, start, low_t, high_t, last_bit, done;

  int pass_cnt = 0;
  int total_cnt = 0;

  spi_master_datapath #(
    .DATA_W(DATA_W), .HALF_PERIOD(HALF_PERIOD), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clock(clock), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .inc_bit(inc_bit), .idle(idle), .count(count),
    .bit_in(bit_in), .sclk_in(sclk_in), .start(start), .low_t(low_t),
    .high_t(high_t), .last_bit(last_bit), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: how long idle/count have been in their active state, which word
  // was accepted, and how many of its bits have been consumed.
  int                run;
  int                crun;
  int                m_bits;
  logic [DATA_W-1:0] m_word;
  logic              m_start;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run <= 0; crun <= 0; m_bits <= 0; m_word <= '0; m_start <= 1'b0;
    end else begin
      run  <= idle ? 0 : run + 1;
      crun <= count ? crun + 1 : 0;
      if (tx_valid && idle && !m_start) begin
        m_start <= 1'b1;
        m_word  <= tx_data;
        m_bits  <= 0;
      end else begin
        if (!idle) m_start <= 1'b0;
        if (inc_bit && m_bits < DATA_W) m_bits <= m_bits + 1;
      end
    end
  end

  logic e_sclk, e_tc, e_low, e_high, e_bit, e_last, e_done, e_ready;

  always @(negedge clock) begin
    if (reset_n) begin
      e_ready = idle && !m_start;
      e_sclk  = ((run / HALF_PERIOD) % 2) == 1;
      e_tc    = !idle && (((run + 1) % HALF_PERIOD) == 0);
      e_low   = e_tc && ((((run + 1) / HALF_PERIOD) % 2) == 1);
      e_high  = e_tc && ((((run + 1) / HALF_PERIOD) % 2) == 0);
      if (m_bits >= DATA_W) e_bit = 1'b0;
`ifdef SPI_LSB_FIRST_EN
      else e_bit = m_word[m_bits];
`else
      else e_bit = m_word[DATA_W-1-m_bits];
`endif
      e_last = (m_bits == DATA_W - 1);
      e_done = count && (crun >= WAIT_CYCLES - 1);
      check("tx_ready", 32'(tx_ready), 32'(e_ready));
      check("start",    32'(start),    32'(m_start));
      check("sclk_in",  32'(sclk_in),  32'(e_sclk));
      check("low_t",    32'(low_t),    32'(e_low));
      check("high_t",   32'(high_t),   32'(e_high));
      check("bit_in",   32'(bit_in),   32'(e_bit));
      check("last_bit", 32'(last_bit), 32'(e_last));
      check("done",     32'(done),     32'(e_done));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer a word while idle, then play the FSM leaving IDLE one edge after start rises.
  task automatic send_word(input logic [DATA_W-1:0] w);
    int st;
    st = 0;
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clock);
    check("ready_before_accept", 32'(tx_ready), 32'd1);
    tick();
    tx_valid = 1'b0;
    @(negedge clock);
    st = st + 32'(start);
    check("ready_after_accept", 32'(tx_ready), 32'd0);
    tick();
    idle = 1'b0;
    @(negedge clock);
    st = st + 32'(start);
    tick();
    @(negedge clock);
    st = st + 32'(start);
    check("start_cycles", 32'(st), 32'd2);
  endtask

  // Pulse inc_bit once per sclk period; capture bit_in and last_bit in the inc_bit cycle.
  task automatic shift_bits(input int nbits, output logic [DATA_W-1:0] seq,
                            output logic [DATA_W-1:0] lastm);
    seq   = '0;
    lastm = '0;
    for (int b = 0; b < nbits; b++) begin
      repeat (2 * HALF_PERIOD - 1) tick();
      inc_bit = 1'b1;
      @(negedge clock);
      seq[DATA_W-1-b]   = bit_in;
      lastm[DATA_W-1-b] = last_bit;
      tick();
      inc_bit = 1'b0;
    end
  endtask

  task automatic gap_and_idle();
    int first;
    first = -1;
    count = 1'b1;
    for (int i = 1; i <= 10 && first < 0; i++) begin
      @(negedge clock);
      if (done) first = i;
      else tick();
    end
    check("done_latency", 32'(first), 32'(WAIT_CYCLES));
    tick();
    @(negedge clock);
    check("done_held", 32'(done), 32'd1);
    tick();
    count = 1'b0;
    idle  = 1'b1;
    @(negedge clock);
    check("done_drop", 32'(done), 32'd0);
    tick();
  endtask

  logic [DATA_W-1:0] seq, lastm;
  logic [31:0]       lowm, highm;
  int                seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 reset_n = 1'b1;
    @(negedge clock);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_start",    32'(start),    32'd0);
    check("rst_sclk",     32'(sclk_in),  32'd0);
    check("rst_low_t",    32'(low_t),    32'd0);
    check("rst_high_t",   32'(high_t),   32'd0);
    check("rst_bit_in",   32'(bit_in),   32'd0);
    check("rst_last_bit", 32'(last_bit), 32'(DATA_W == 1));
    check("rst_done",     32'(done),     32'd0);

    // Free-running divider: idle low for 20 cycles, numbered from 1.
    tick();
    idle  = 1'b0;
    lowm  = '0;
    highm = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (low_t) lowm[c] = 1'b1;
      if (high_t) highm[c] = 1'b1;
      tick();
    end
    idle = 1'b1;
    check("low_t_positions",  lowm,  32'h0010_1010);
    check("high_t_positions", highm, 32'h0001_0100);
    tick();

    // Full frame of 8'hA5 (same bit order either way since the pattern is a palindrome).
    send_word(8'hA5);
    shift_bits(DATA_W, seq, lastm);
    check("a5_bit_sequence", 32'(seq),   32'h0000_00A5);
    check("a5_last_bit",     32'(lastm), 32'h0000_0001);
    gap_and_idle();

    // Reset mid-frame after three bits, taken while sclk is high.
    send_word(8'h96);
    shift_bits(3, seq, lastm);
    seen = 0;
    for (int i = 0; i < 2 * HALF_PERIOD && seen == 0; i++) begin
      @(negedge clock);
      if (sclk_in) seen = 1;
      else tick();
    end
    check("sclk_high_before_reset", 32'(seen), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_start",    32'(start),    32'd0);
    check("mid_rst_sclk",     32'(sclk_in),  32'd0);
    check("mid_rst_low_t",    32'(low_t),    32'd0);
    check("mid_rst_high_t",   32'(high_t),   32'd0);
    check("mid_rst_bit_in",   32'(bit_in),   32'd0);
    check("mid_rst_last_bit", 32'(last_bit), 32'(DATA_W == 1));
    idle = 1'b1;
    tick();
    @(negedge clock);
    #2 reset_n = 1'b1;
    tick();

    send_word(8'h3C);
    shift_bits(DATA_W, seq, lastm);
    check("3c_bit_sequence", 32'(seq),   32'h0000_003C);
    check("3c_last_bit",     32'(lastm), 32'h0000_0001);
    gap_and_idle();

    send_word(8'h01);
    shift_bits(DATA_W, seq, lastm);
`ifdef SPI_LSB_FIRST_EN
    check("01_bit_sequence", 32'(seq), 32'h0000_0080);
`else
    check("01_bit_sequence", 32'(seq), 32'h0000_0001);
`endif
    check("01_last_bit", 32'(lastm), 32'h0000_0001);
    gap_and_idle();

    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_master_datapath.md
# spi_master_datapath

Timing and data path that drives the SPI master control FSM. It accepts a parallel word from the host over a valid/ready handshake, raises the FSM's start request, and generates the serial clock with its end-of-half-period strobes. It also serializes the word onto the bit output, flags the last bit, and times the post-frame wait. It consumes the FSM's inc_bit, idle and count status lines.

## Interface
- DATA_W, 8: frame length in bits, ≥1.
- HALF_PERIOD, 4: system clocks per sclk half period, ≥1.
- WAIT_CYCLES, 2: clocks of inter-frame gap counted in the FSM's WAIT state, ≥1.

- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  host has a word.
- tx_ready  out  1  word accepted on an edge where tx_valid && tx_ready.
- inc_bit  in  1  from FSM: advance to next bit.
- idle  in  1  from FSM: FSM in IDLE.
- count  in  1  from FSM: FSM in WAIT, count gap.
- bit_in  out  1  current serial bit to FSM.
- sclk_in  out  1  divided serial clock to FSM (CPOL=0).
- start  out  1  frame request to FSM.
- low_t  out  1  one-cycle strobe: last clock of an sclk-low half period.
- high_t  out  1  one-cycle strobe: last clock of an sclk-high half period.
- last_bit  out  1  current bit is the final bit of the frame.
- done  out  1  inter-frame gap complete.

## Operation
- Registers: shreg[DATA_W], bit_cnt (clog2(DATA_W+1) bits), div_cnt (clog2(HALF_PERIOD+1) bits), sclk_q, start_q, gap_cnt (clog2(WAIT_CYCLES+1) bits).
- Handshake: tx_ready = idle && !start_q (combinational). On accept: shreg ← tx_data, bit_cnt ← 0, start_q ← 1. start = start_q. start_q clears on the first edge where idle is sampled 0. tx_valid while tx_ready=0 is ignored; no data is lost because the host holds tx_valid.
- Divider: while idle=1, div_cnt ← 0 and sclk_q ← 0. While idle=0, div_cnt increments. At div_cnt == HALF_PERIOD-1: div_cnt ← 0 and sclk_q toggles. sclk_in = sclk_q.
- Strobes (combinational): tc = !idle && div_cnt == HALF_PERIOD-1. low_t = tc && !sclk_q. high_t = tc && sclk_q. The first strobe after leaving IDLE is low_t.
- Serializer: bit_in = shreg[DATA_W-1], MSB first. On inc_bit: shreg shifts left by one with zero fill, and bit_cnt increments, saturating at DATA_W. last_bit = (bit_cnt == DATA_W-1), combinational; it is valid in the same cycle as inc_bit.
- Gap timer: while count=1, gap_cnt increments, saturating. When count=0, gap_cnt ← 0. done = count && gap_cnt == WAIT_CYCLES-1.
- When idle returns to 1, shreg and bit_cnt hold their values until the next accept. The divider clears per the rule above.

## Timing
- Reset values: tx_ready = idle; start 0; sclk_in 0; low_t 0; high_t 0; bit_in 0 (shreg=0); last_bit = (DATA_W==1); done 0.
- Asynchronous reset mid-frame clears every register immediately. Outputs take their reset values within the same cycle.
- Accept at edge k sets start=1 after edge k. The FSM leaves IDLE at edge k+1, and start clears at edge k+2. Start is high for exactly 2 cycles. tx_ready is 0 from edge k until the FSM re-enters IDLE.
- sclk period is 2·HALF_PERIOD clocks, 50% duty. Exactly one strobe fires per HALF_PERIOD clocks while idle=0.
- bit_in changes the cycle after the inc_bit edge. The FSM then drives it during the following TRANSMIT.
- inc_bit coinciding with a strobe is legal. Each updates independently.
- done asserts WAIT_CYCLES clocks after count rises and stays high while count remains 1.

## Configuration
- SPI_LSB_FIRST_EN: when defined, bit_in = shreg[0], and inc_bit shifts right with zero fill. When undefined, the default is MSB first as above. Counter, strobe and handshake behaviour is identical in both builds.

## Test plan
- Reset then release with idle=1, tx_valid=0: all outputs at reset values; tx_ready=1.
- DATA_W=8, HALF_PERIOD=4: accept 8'hA5, FSM model present → start high 2 cycles; bit_in sequence 1,0,1,0,0,1,0,1; last_bit high only on the 8th inc_bit.
- Divider with idle=0: low_t at clocks 4, 12, 20 and high_t at clocks 8, 16; sclk_in toggles at each strobe edge.
- count held high, WAIT_CYCLES=2 → done high from the 2nd cycle; count drop → done 0 and gap_cnt 0.
- Assert reset_n=0 mid-frame after 3 bits → start, sclk_in and strobes 0 immediately. After release and idle=1, new word 8'h3C transmits from its first bit.
- SPI_LSB_FIRST_EN build: word 8'h01 → bit_in 1 then seven 0s.
